// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB first, WIDTH cycles per add.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        // Last bit: carry_q is the carry into the MSB, fa_co the carry out of it.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = psum_d;
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level reference model plus directed literal checks.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: unsigned sum for sum/cout, signed range test for overflow.
  function automatic void calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                               output logic [W-1:0] s, output logic co, output logic ov);
    int u;
    int sv;
    u  = int'(x) + int'(y) + int'(c);
    sv = int'($signed(x)) + int'($signed(y)) + int'(c);
    s  = u[W-1:0];
    co = (u >= (1 << W));
    ov = (sv > ((1 << (W-1)) - 1)) || (sv < -(1 << (W-1)));
  endfunction

  // Model: remaining cycles of the current add; zero means ready to accept.
  int           m_rem = 0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W-1:0] p_sum = '0;
  logic         p_cout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_done = 1'b1;
        end
      end else if (start) begin
        calc(a, b, cin, p_sum, p_cout, p_ovf);
        m_rem = W;
      end
      m_busy = (m_rem > 0);
    end
  end

  logic prev_done = 1'b0;
  always @(negedge clk) begin
    checks++;
    if (busy !== m_busy || done !== m_done || sum !== m_sum || cout !== m_cout || ovf !== m_ovf) begin
      failures++;
      $display("FAIL cycle_model t=%0t got busy=%b done=%b sum=%h cout=%b ovf=%b exp busy=%b done=%b sum=%h cout=%b ovf=%b",
               $time, busy, done, sum, cout, ovf, m_busy, m_done, m_sum, m_cout, m_ovf);
    end
    if (done === 1'b1 && prev_done === 1'b1) begin
      failures++;
      $display("FAIL done_consecutive t=%0t got done twice required single pulse", $time);
    end
    prev_done = done;
  end

  task automatic check_lit(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; pulses start across exactly one rising edge.
  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    start = 1'b1; a = x; b = y; cin = c;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; cin = $urandom;
  endtask

  task automatic wait_done(output int busy_cycles);
    int n;
    busy_cycles = 0;
    for (n = 0; n < 4*W && done !== 1'b1; n++) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got done=%b exp 1 within %0d cycles", done, 4*W);
    end
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    int bc;
    do_start(x, y, c);
    wait_done(bc);
    check_lit({name, "_sum"}, sum, es);
    check_lit({name, "_cout"}, W'(cout), W'(ec));
    check_lit({name, "_ovf"}, W'(ovf), W'(eo));
    @(negedge clk);
  endtask

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_lit("reset_busy", W'(busy), '0);
    check_lit("reset_done", W'(done), '0);
    check_lit("reset_sum", sum, '0);
    check_lit("reset_flags", W'({cout, ovf}), '0);

    do_start(8'h5A, 8'h33, 1'b0);
    wait_done(bc);
    check_lit("t1_sum", sum, 8'h8D);
    check_lit("t1_cout", W'(cout), 8'h00);
    check_lit("t1_ovf", W'(ovf), 8'h01);
    check_lit("t1_busy_cycles", W'(bc), 8'd8);
    @(negedge clk);

    run_lit("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_lit("t3", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

    do_start(8'h11, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    do_start(8'h77, 8'h00, 1'b0);
    wait_done(bc);
    check_lit("midrun_ignored_sum", sum, 8'h33);
    do_start(8'h01, 8'h01, 1'b0);
    check_lit("b2b_busy", W'(busy), 8'h01);
    wait_done(bc);
    check_lit("b2b_sum", sum, 8'h02);
    check_lit("b2b_busy_cycles", W'(bc), 8'd8);
    @(negedge clk);

    do_start(8'h0F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_lit("abort_busy", W'(busy), '0);
    check_lit("abort_sum", sum, '0);
    check_lit("abort_flags", W'({done, cout, ovf}), '0);
    repeat (W + 2) @(negedge clk);
    check_lit("abort_no_done", W'(done), '0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_lit("after_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = $urandom; b = $urandom; cin = $urandom;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial two's-complement adder, the addition counterpart of the team's subtractor cells. It accepts two WIDTH-bit operands and a carry-in on a start pulse. It adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop, then presents the sum, carry-out and signed overflow with a one-cycle done pulse. It serves area-constrained datapaths in the FPGA designs where a WIDTH-bit ripple adder is not wanted.

## Interface
Parameters:
- WIDTH, 8: operand and sum width in bits; legal range is 2 or more.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results valid from this cycle.
- sum  out  WIDTH  result of a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- The block has one clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE.
- IDLE: start=1 causes the following:
  - Load shift registers sa<=a, sb<=b.
  - Load carry<=cin.
  - Clear bit counter cnt<=0.
  - Move to RUN.
- RUN: each edge performs the following:
  - Full-adder cell computes s = sa[0]^sb[0]^carry and co = sa[0]&sb[0] | carry&(sa[0]^sb[0]).
  - s shifts into the MSB of the internal partial-sum register, and sa, sb shift right.
  - carry<=co and cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, the result registers load:
    - sum <= final partial sum.
    - cout <= co.
    - ovf <= carry (carry into MSB) ^ co.
  - The state then moves to DONE.
- DONE: done=1 for exactly one cycle. Next state:
  - RUN if start=1 (back-to-back operation; operands are captured as in IDLE).
  - IDLE otherwise.
- start in RUN is ignored and has no effect on operands or state.
- sum, cout and ovf change only at completion. They hold their values through IDLE and through the next RUN until that run completes.
- The counter width is $clog2(WIDTH). cnt never wraps during normal operation, because RUN exits at WIDTH-1.
- Reset values: state IDLE. busy, done, sum, cout and ovf are all 0. Internal registers are 0.
- Reset asserted mid-RUN aborts the operation immediately (asynchronously). No done is produced and the previous results are cleared to 0.
- Inputs a, b and cin are don't-care outside the accepting edge.

## Timing
- Edge 0: start is sampled and the state enters RUN; busy=1 after edge 0.
- Edges 1..WIDTH: one bit is processed per edge. Results and done=1 are visible after edge WIDTH; busy=0 at the same time.
- Latency from the start edge to done is WIDTH cycles.
- Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- done is never asserted on two consecutive cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- serial_adder_pkg contains the following:
  - State enum: IDLE, RUN, DONE (2-bit).
  - Default WIDTH constant.
- Sub-module full_adder: combinational cell with inputs a, b, c and outputs s, co. It is instantiated once in the datapath and is reusable elsewhere in the codebase.
- The top level contains the FSM, the shift registers, the carry flip-flop, the counter and the result registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert rst_n=0 at time 0 and release -> busy, done, sum, cout and ovf are all 0, and the state is IDLE.
- a=0x5A, b=0x33, cin=0, start pulse -> done 8 cycles later with sum=0x8D, cout=0, ovf=1; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
- a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- start with a=0x11, b=0x22 re-pulsed mid-RUN with a=0x77 -> the mid-RUN start is ignored and the result is 0x33.
  - Also assert start during the done cycle with a=0x01, b=0x01 -> accepted, and a second done follows 8 cycles later with sum=0x02.
- Drive rst_n low after 4 RUN edges of an operation with a=0x0F, b=0x01 -> the operation aborts with no done pulse and all outputs 0.
  - After releasing reset, a new start with a=0x0F, b=0x01 -> sum=0x10.
